// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with memory-ready handshake, optional addi/j decode and illegal-instruction detection.
module multicycle_control_unit #(
    parameter logic ENABLE_ADDI = 1'b1,
    parameter logic ENABLE_JUMP = 1'b1,
    parameter logic MEM_WAIT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic       mem_ready_s;
    logic       funct_ok_s;
    logic       op_illegal_s;
    logic [1:0] alu_op_s;

    // Raw (pre-reset-gating) strobes from the state decode
    logic pc_write_s, branch_s, mem_write_s, ir_write_s, reg_write_s, illegal_s;

    assign mem_ready_s = MEM_WAIT ? MemReady : 1'b1;

    // Classify the current Op and Funct fields
    always_comb begin
        funct_ok_s   = 1'b0;
        op_illegal_s = 1'b0;
        case (Funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok_s = 1'b1;
            default:                               funct_ok_s = 1'b0;
        endcase
        case (Op)
            OP_LW, OP_SW, OP_RTYP, OP_BEQ: op_illegal_s = 1'b0;
            OP_ADDI:                       op_illegal_s = ~ENABLE_ADDI;
            OP_J:                          op_illegal_s = ~ENABLE_JUMP;
            default:                       op_illegal_s = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready_s) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYP:      next_state_s = S_EXECUTE;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = ENABLE_ADDI ? S_ADDIEX : S_FETCH;
                    OP_J:         next_state_s = ENABLE_JUMP ? S_JUMP : S_FETCH;
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready_s) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready_s) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXECUTE: begin
                if (funct_ok_s) begin
                    next_state_s = S_ALUWB;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_ADDIEX: next_state_s = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // State register; an asserted reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Moore output decode (plus MemReady in FETCH and Funct in EXECUTE)
    always_comb begin
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        IorD        = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        reg_write_s = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        alu_op_s    = 2'b00;
        illegal_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ir_write_s = mem_ready_s;
                pc_write_s = mem_ready_s;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                illegal_s = op_illegal_s;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA   = 1'b1;
                alu_op_s  = 2'b10;
                illegal_s = ~funct_ok_s;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                alu_op_s = 2'b01;
                PCSrc    = 2'b01;
                branch_s = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            S_JUMP: begin
                PCSrc      = 2'b10;
                pc_write_s = 1'b1;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // ALU decoder
    always_comb begin
        ALUControl = 3'b010;
        case (alu_op_s)
            2'b00: ALUControl = 3'b010;
            2'b01: ALUControl = 3'b110;
            2'b10: begin
                case (Funct)
                    FN_ADD:  ALUControl = 3'b010;
                    FN_SUB:  ALUControl = 3'b110;
                    FN_AND:  ALUControl = 3'b000;
                    FN_OR:   ALUControl = 3'b001;
                    FN_SLT:  ALUControl = 3'b111;
                    default: ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    // Write/load strobes are held low while reset is asserted, not just once it is sampled
    assign PCWrite      = rst_n & pc_write_s;
    assign Branch       = rst_n & branch_s;
    assign MemWrite     = rst_n & mem_write_s;
    assign IRWrite      = rst_n & ir_write_s;
    assign RegWrite     = rst_n & reg_write_s;
    assign IllegalInstr = rst_n & illegal_s;
    assign State        = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one default-parameter instance plus one
// instance with ADDI/J disabled and MemReady ignored.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       MemReady;

    logic       PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, IllegalInstr;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic       z_PCWrite, z_Branch, z_IorD, z_MemWrite, z_IRWrite, z_RegDst, z_MemtoReg, z_RegWrite, z_ALUSrcA, z_IllegalInstr;
    logic [1:0] z_ALUSrcB, z_PCSrc;
    logic [2:0] z_ALUControl;
    logic [3:0] z_State;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
        .IllegalInstr(IllegalInstr), .State(State)
    );

    multicycle_control_unit #(.ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0), .MEM_WAIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .PCWrite(z_PCWrite), .Branch(z_Branch), .IorD(z_IorD), .MemWrite(z_MemWrite),
        .IRWrite(z_IRWrite), .RegDst(z_RegDst), .MemtoReg(z_MemtoReg), .RegWrite(z_RegWrite),
        .ALUSrcA(z_ALUSrcA), .ALUSrcB(z_ALUSrcB), .PCSrc(z_PCSrc), .ALUControl(z_ALUControl),
        .IllegalInstr(z_IllegalInstr), .State(z_State)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {7'd0, obs}, {7'd0, exp});
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        chk(tag, {6'd0, obs}, {6'd0, exp});
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        chk(tag, {5'd0, obs}, {5'd0, exp});
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        chk(tag, {4'd0, obs}, {4'd0, exp});
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; Op = 6'b000000; Funct = 6'b000000; MemReady = 1'b1;
        #12;
        // Reset values
        chk4("rst_state", State, 4'd0);
        chk2("rst_alusrcb", ALUSrcB, 2'b01);
        chk3("rst_aluctl", ALUControl, 3'b010);
        chk1("rst_pcwrite", PCWrite, 1'b0);
        chk1("rst_irwrite", IRWrite, 1'b0);
        chk1("rst_illegal", IllegalInstr, 1'b0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk1("fetch_irwrite", IRWrite, 1'b1);
        chk1("fetch_pcwrite", PCWrite, 1'b1);

        // Reset mid-lw
        Op = 6'b100011;
        tick(); chk4("rlw_s1", State, 4'd1);
        tick(); chk4("rlw_s2", State, 4'd2);
        tick(); chk4("rlw_s3", State, 4'd3);
        chk1("rlw_iord", IorD, 1'b1);
        rst_n = 1'b0; #1;
        chk4("rlw_abort_state", State, 4'd0);
        chk1("rlw_abort_regwrite", RegWrite, 1'b0);
        chk1("rlw_abort_iord", IorD, 1'b0);
        @(negedge clk); rst_n = 1'b1; MemReady = 1'b1;
        tick(); chk4("rlw_release", State, 4'd1);
        tick(); tick(); tick(); tick();
        chk4("rlw_back_fetch", State, 4'd0);

        // lw, MemReady held high
        Op = 6'b100011;
        tick(); chk4("lw_s1", State, 4'd1); chk2("lw_dec_alusrcb", ALUSrcB, 2'b11);
        tick(); chk4("lw_s2", State, 4'd2); chk1("lw_adr_srca", ALUSrcA, 1'b1); chk2("lw_adr_srcb", ALUSrcB, 2'b10);
        tick(); chk4("lw_s3", State, 4'd3); chk1("lw_rd_regwrite", RegWrite, 1'b0);
        tick(); chk4("lw_s4", State, 4'd4); chk1("lw_wb_regwrite", RegWrite, 1'b1);
        chk1("lw_wb_memtoreg", MemtoReg, 1'b1); chk1("lw_wb_regdst", RegDst, 1'b0);
        tick(); chk4("lw_s0", State, 4'd0); chk1("lw_end_regwrite", RegWrite, 1'b0);

        // FETCH wait, then sw with 2 wait cycles in MEMWR
        Op = 6'b101011; MemReady = 1'b0; #1;
        chk1("fetchwait_irwrite", IRWrite, 1'b0);
        tick(); chk4("fetchwait_hold", State, 4'd0);
        MemReady = 1'b1;
        tick(); chk4("sw_s1", State, 4'd1);
        tick(); chk4("sw_s2", State, 4'd2);
        tick(); chk4("sw_s5", State, 4'd5);
        MemReady = 1'b0; #1;
        chk1("sw_memwrite1", MemWrite, 1'b1); chk1("sw_iord", IorD, 1'b1);
        tick(); chk4("sw_hold1", State, 4'd5); chk1("sw_memwrite2", MemWrite, 1'b1);
        tick(); chk4("sw_hold2", State, 4'd5);
        MemReady = 1'b1; #1;
        chk1("sw_memwrite3", MemWrite, 1'b1);
        tick(); chk4("sw_done", State, 4'd0); chk1("sw_end_memwrite", MemWrite, 1'b0);

        // R-type: sub, slt, then unsupported Funct
        Op = 6'b000000; Funct = 6'b100010;
        tick(); tick(); chk4("sub_s6", State, 4'd6); chk3("sub_aluctl", ALUControl, 3'b110);
        chk1("sub_srca", ALUSrcA, 1'b1);
        tick(); chk4("sub_s7", State, 4'd7); chk1("sub_regdst", RegDst, 1'b1); chk1("sub_regwrite", RegWrite, 1'b1);
        Funct = 6'b100101;
        tick(); chk4("sub_s0", State, 4'd0);
        Funct = 6'b101010;
        tick(); tick(); chk3("slt_aluctl", ALUControl, 3'b111);
        tick(); chk1("slt_regdst", RegDst, 1'b1);
        tick(); chk4("slt_s0", State, 4'd0);
        Funct = 6'b000000;
        tick(); chk1("badfn_dec_illegal", IllegalInstr, 1'b0);
        tick(); chk4("badfn_s6", State, 4'd6); chk1("badfn_illegal", IllegalInstr, 1'b1);
        chk1("badfn_regwrite", RegWrite, 1'b0); chk3("badfn_aluctl", ALUControl, 3'b010);
        tick(); chk4("badfn_s0", State, 4'd0); chk1("badfn_end_illegal", IllegalInstr, 1'b0);
        chk1("badfn_end_regwrite", RegWrite, 1'b0);

        // beq and j
        Op = 6'b000100;
        tick(); tick(); chk4("beq_s8", State, 4'd8); chk1("beq_branch", Branch, 1'b1);
        chk2("beq_pcsrc", PCSrc, 2'b01); chk3("beq_aluctl", ALUControl, 3'b110);
        tick(); chk4("beq_s0", State, 4'd0);
        Op = 6'b000010;
        tick(); tick(); chk4("j_s11", State, 4'd11); chk1("j_pcwrite", PCWrite, 1'b1);
        chk2("j_pcsrc", PCSrc, 2'b10);
        tick(); chk4("j_s0", State, 4'd0);

        // addi, enabled
        Op = 6'b001000;
        tick(); chk1("addi_dec_illegal", IllegalInstr, 1'b0);
        tick(); chk4("addi_s9", State, 4'd9); chk2("addi_srcb", ALUSrcB, 2'b10);
        tick(); chk4("addi_s10", State, 4'd10); chk1("addi_regwrite", RegWrite, 1'b1);
        tick(); chk4("addi_s0", State, 4'd0);

        // Unknown opcode
        Op = 6'b111111;
        tick(); chk4("badop_s1", State, 4'd1); chk1("badop_illegal", IllegalInstr, 1'b1);
        tick(); chk4("badop_s0", State, 4'd0); chk1("badop_end_illegal", IllegalInstr, 1'b0);

        // Parameters off: resync both instances through reset
        rst_n = 1'b0; #2; rst_n = 1'b1;
        Op = 6'b001000; MemReady = 1'b0; #1;
        chk1("p0_fetch_irwrite", z_IRWrite, 1'b1);
        tick(); chk4("p0_addi_s1", z_State, 4'd1); chk1("p0_addi_illegal", z_IllegalInstr, 1'b1);
        tick(); chk4("p0_addi_s0", z_State, 4'd0); chk1("p0_addi_regwrite", z_RegWrite, 1'b0);
        Op = 6'b000010;
        tick(); chk1("p0_j_illegal", z_IllegalInstr, 1'b1);
        tick(); chk4("p0_j_s0", z_State, 4'd0);
        Op = 6'b100011;
        tick(); tick(); tick(); chk4("p0_lw_s3", z_State, 4'd3);
        tick(); chk4("p0_lw_s4", z_State, 4'd4); chk1("p0_lw_regwrite", z_RegWrite, 1'b1);
        tick(); chk4("p0_lw_s0", z_State, 4'd0);
        chk4("dflt_fetch_hold", State, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
